// File: rtl/unidade_controle.sv
// ============================================================================
//  Module      : unidade_controle
//  Description : Instruction sequencer sitting in front of the matrix ALU.
//                Host instructions fill operand registers A and B (25 signed
//                bytes each, row-major). ALU operations drive the ALU and wait
//                for its done. The 200-bit result is captured and its
//                elements are served back to the host with STORE.
//
//  Instruction : op[3:0], sel[4] (0=A, 1=B), idx[9:5], data[17:10]
//
//  Ports
//    clk, reset        : rising-edge clock, synchronous active-high reset
//    instr/_valid      : host instruction word and its qualifier
//    instr_ready       : high only in IDLE while reset is low
//    rd_data/rd_valid  : result element returned by STORE (one-cycle pulse)
//    busy              : high in every state other than IDLE
//    err               : sticky error flag, cleared by reset or an accepted NOP
//    alu_opcode        : ALU opcode (0000 outside EXEC)
//    alu_escalar       : ALU scalar operand, latched when the ALU op is accepted
//    alu_matrizA/B     : operand registers A and B
//    alu_resultado     : ALU result matrix
//    alu_done          : ALU done level (stale for one cycle after a new op)
//
//  Build option
//    CLEAR_CMD_EN      : when defined, op 1101 (CLR) zeroes A or B through the
//                        LOAD state; when undefined, 1101 is an invalid op.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_controle #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [7:0]   rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic         err,
    output logic [3:0]   alu_opcode,
    output logic [7:0]   alu_escalar,
    output logic [199:0] alu_matrizA,
    output logic [199:0] alu_matrizB,
    input  logic [199:0] alu_resultado,
    input  logic         alu_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_EXEC  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    localparam logic [3:0]    c_OP_NOP    = 4'h0;
    localparam logic [3:0]    c_OP_LOAD   = 4'h1;
    localparam logic [3:0]    c_OP_STORE  = 4'h2;
    localparam logic [3:0]    c_OP_ALU_LO = 4'h3;
    localparam logic [3:0]    c_OP_ALU_HI = 4'hC;
    localparam logic [4:0]    c_N_ELEM    = 5'd25;
    // Counter holds (EXEC cycle number - 1), so this value marks the last
    // permitted EXEC cycle.
    localparam logic [TW-1:0] c_TMO_LAST  = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [199:0]    r_mat_a;
    logic [199:0]    r_mat_b;
    logic [199:0]    r_result;
    logic [3:0]      r_alu_opcode;
    logic [7:0]      r_escalar;
    logic [7:0]      r_rd_data;
    logic            r_rd_valid;
    logic            r_err;
    logic            r_sel;
    logic [4:0]      r_idx;
    logic [7:0]      r_data;
    logic            r_clr;
    logic [TW-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [3:0] w_op;
    logic       w_sel;
    logic [4:0] w_idx;
    logic [7:0] w_data;
    logic       w_accept;
    logic       w_idx_ok;
    logic       w_is_alu;
    logic       w_is_clr;
    logic [7:0] w_in_off;
    logic [7:0] w_reg_off;
    logic       w_unused_instr;

    assign w_op      = instr[3:0];
    assign w_sel     = instr[4];
    assign w_idx     = instr[9:5];
    assign w_data    = instr[17:10];
    assign w_accept  = instr_valid && instr_ready;
    assign w_idx_ok  = (w_idx < c_N_ELEM);
    assign w_is_alu  = (w_op >= c_OP_ALU_LO) && (w_op <= c_OP_ALU_HI);
    // Byte offset of an element: idx*8 (max 24*8 = 192 fits in 8 bits)
    assign w_in_off  = {w_idx, 3'b000};
    assign w_reg_off = {r_idx, 3'b000};
    assign w_unused_instr = ^instr[31:18];

`ifdef CLEAR_CMD_EN
    assign w_is_clr = (w_op == 4'hD);
`else
    assign w_is_clr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mat_a      <= '0;
            r_mat_b      <= '0;
            r_result     <= '0;
            r_alu_opcode <= 4'h0;
            r_escalar    <= 8'h00;
            r_rd_data    <= 8'h00;
            r_rd_valid   <= 1'b0;
            r_err        <= 1'b0;
            r_sel        <= 1'b0;
            r_idx        <= 5'd0;
            r_data       <= 8'h00;
            r_clr        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_op == c_OP_NOP) begin
                            r_err <= 1'b0;
                        end else if (w_op == c_OP_LOAD) begin
                            if (w_idx_ok) begin
                                r_sel   <= w_sel;
                                r_idx   <= w_idx;
                                r_data  <= w_data;
                                r_clr   <= 1'b0;
                                r_state <= S_LOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_op == c_OP_STORE) begin
                            if (w_idx_ok) begin
                                r_rd_data  <= r_result[w_in_off +: 8];
                                r_rd_valid <= 1'b1;
                                r_state    <= S_STORE;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_is_alu) begin
                            r_alu_opcode <= w_op;
                            r_escalar    <= w_data;
                            r_cnt        <= '0;
                            r_state      <= S_EXEC;
                        end else if (w_is_clr) begin
                            r_sel   <= w_sel;
                            r_clr   <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (r_clr) begin
                        if (r_sel) r_mat_b <= '0;
                        else       r_mat_a <= '0;
                    end else begin
                        if (r_sel) r_mat_b[w_reg_off +: 8] <= r_data;
                        else       r_mat_a[w_reg_off +: 8] <= r_data;
                    end
                    r_clr   <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_STORE: begin
                    r_state <= S_IDLE;
                end

                S_EXEC: begin
                    // done on the first EXEC cycle belongs to the previous
                    // operation; done beats timeout when both coincide.
                    if ((r_cnt != '0) && alu_done) begin
                        r_result     <= alu_resultado;
                        r_alu_opcode <= 4'h0;
                        r_state      <= S_CLEAR;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_err        <= 1'b1;
                        r_alu_opcode <= 4'h0;
                        r_state      <= S_CLEAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_CLEAR: begin
                    // Wait for the ALU to drop done so the next op starts clean
                    if (!alu_done) r_state <= S_IDLE;
                end

                default: begin
                    r_alu_opcode <= 4'h0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_ready = (r_state == S_IDLE) && !reset;
    assign busy        = (r_state != S_IDLE);
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign err         = r_err;
    assign alu_opcode  = r_alu_opcode;
    assign alu_escalar = r_escalar;
    assign alu_matrizA = r_mat_a;
    assign alu_matrizB = r_mat_b;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle.sv
// ============================================================================
//  Module      : tb_unidade_controle
//  Description : Self-checking bench for unidade_controle. A behavioural ALU
//                model answers the sequencer; STORE expectations are queued
//                at issue time and a monitor compares them against rd_valid
//                pulses. Register and flag checks use hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidade_controle;

    localparam int TIMEOUT = 64;
    localparam int M_ADD   = 0;
    localparam int M_NEVER = 1;
    localparam int M_STALE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic         busy;
    logic         err;
    logic [3:0]   alu_opcode;
    logic [7:0]   alu_escalar;
    logic [199:0] alu_matrizA;
    logic [199:0] alu_matrizB;
    logic [199:0] alu_resultado = '0;
    logic         alu_done = 1'b0;

    always #5 clk = ~clk;

    unidade_controle #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .err          (err),
        .alu_opcode   (alu_opcode),
        .alu_escalar  (alu_escalar),
        .alu_matrizA  (alu_matrizA),
        .alu_matrizB  (alu_matrizB),
        .alu_resultado(alu_resultado),
        .alu_done     (alu_done)
    );

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [7:0]   exp_q[$];
    logic [199:0] exp_a = '0;
    logic [199:0] exp_b = '0;
    int           mode  = M_ADD;
    int           ecnt  = 0;
    int           ccnt  = 0;

    function automatic logic [199:0] add_mat(input logic [199:0] a, input logic [199:0] b);
        logic [199:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        return r;
    endfunction

    // ALU model: updates mid-cycle so the DUT sees stable inputs at posedge
    always @(negedge clk) begin
        if (alu_opcode != 4'h0) begin
            ecnt = ecnt + 1;
            ccnt = 0;
            if (mode == M_ADD) begin
                if (ecnt >= 2) begin
                    alu_resultado = add_mat(alu_matrizA, alu_matrizB);
                    alu_done      = 1'b1;
                end else begin
                    alu_done = 1'b0;
                end
            end else if (mode == M_NEVER) begin
                alu_resultado = {25{8'hEE}};
                alu_done      = 1'b0;
            end else begin
                if (ecnt == 1) begin
                    alu_resultado = {25{8'hEE}};
                    alu_done      = 1'b1;
                end else if (ecnt == 2) begin
                    alu_done = 1'b0;
                end else begin
                    alu_resultado = add_mat(alu_matrizA, alu_matrizB);
                    alu_done      = 1'b1;
                end
            end
        end else begin
            ecnt = 0;
            ccnt = ccnt + 1;
            if (!(mode == M_STALE && ccnt < 3)) alu_done = 1'b0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_rd_valid: got rd_data=%0h, required no pulse", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_miss++;
                    $display("FAIL store_data: got %0h, required %0h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        chk(nm, 200'(act), 200'(expv));
    endtask

    task automatic chkn(input string nm, input int act, input int expv);
        chk(nm, 200'(act), 200'(expv));
    endtask

    task automatic issue(input logic [3:0] op, input logic sel, input logic [4:0] idx, input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        instr       = {14'd0, d, idx, sel, op};
        instr_valid = 1'b1;
        while (!instr_ready && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL issue_timeout: got instr_ready=0, required 1");
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic load(input logic sel, input logic [4:0] idx, input logic [7:0] d);
        int c;
        if (sel) exp_b[int'(idx)*8 +: 8] = d;
        else     exp_a[int'(idx)*8 +: 8] = d;
        issue(4'h1, sel, idx, d);
        wait_idle(c);
        chk("load_A", alu_matrizA, exp_a);
        chk("load_B", alu_matrizB, exp_b);
    endtask

    task automatic store(input logic [4:0] idx, input logic [7:0] expv);
        int c;
        exp_q.push_back(expv);
        issue(4'h2, 1'b0, idx, 8'h00);
        wait_idle(c);
    endtask

    task automatic nop();
        int c;
        issue(4'h0, 1'b0, 5'd0, 8'h00);
        wait_idle(c);
        chk1("nop_clears_err", err, 1'b0);
    endtask

    task automatic run_alu(input logic [3:0] op, input logic [7:0] d, input int exp_busy, input string nm);
        int cyc;
        cyc = 0;
        issue(op, 1'b0, 5'd0, d);
        @(negedge clk);
        chk({nm, "_opcode"}, 200'(alu_opcode), 200'(op));
        chk({nm, "_escalar"}, 200'(alu_escalar), 200'(d));
        while (busy && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        chkn({nm, "_busy_cycles"}, cyc, exp_busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int c;
        int rdy_bad;
        int busy_seen;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_instr_ready", instr_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", 200'(rd_data), 200'(0));
        chk("rst_opcode", 200'(alu_opcode), 200'(0));
        chk("rst_escalar", 200'(alu_escalar), 200'(0));
        chk("rst_A", alu_matrizA, '0);
        chk("rst_B", alu_matrizB, '0);
        reset = 1'b0;
        @(negedge clk);
        chk1("ready_after_rst", instr_ready, 1'b1);

        // STORE before any EXEC returns zero
        store(5'd0, 8'h00);

        // Loads and a basic add: 3+5=8 at idx0, 4+0=4 at idx6
        load(1'b0, 5'd0, 8'd3);
        load(1'b0, 5'd6, 8'd4);
        load(1'b1, 5'd0, 8'd5);
        run_alu(4'h3, 8'h5A, 3, "add");
        store(5'd0, 8'd8);
        store(5'd6, 8'd4);

        // Stale done on first EXEC cycle, real done on cycle 3, CLEAR held
        load(1'b1, 5'd6, 8'h10);
        mode = M_STALE;
        run_alu(4'h4, 8'h11, 6, "stale");
        mode = M_ADD;
        store(5'd6, 8'h14);
        store(5'd0, 8'd8);

        // Timeout: 64 EXEC cycles + 1 CLEAR, result unchanged
        mode = M_NEVER;
        load(1'b0, 5'd0, 8'h20);
        run_alu(4'h5, 8'h00, TIMEOUT + 1, "timeout");
        chk1("timeout_err", err, 1'b1);
        chk1("timeout_busy", busy, 1'b0);
        store(5'd0, 8'd8);
        store(5'd6, 8'h14);
        nop();

        // Bad index on LOAD and STORE
        issue(4'h1, 1'b0, 5'd25, 8'h7F);
        wait_idle(c);
        chk1("badidx_load_err", err, 1'b1);
        chk("badidx_load_A", alu_matrizA, exp_a);
        nop();
        issue(4'h2, 1'b0, 5'd31, 8'h00);
        wait_idle(c);
        chk1("badidx_store_err", err, 1'b1);
        nop();

        // Op 1101: CLR when enabled, invalid otherwise
        issue(4'hD, 1'b0, 5'd3, 8'h55);
        wait_idle(c);
`ifdef CLEAR_CMD_EN
        exp_a = '0;
        chk1("clr_err", err, 1'b0);
`else
        chk1("op_d_err", err, 1'b1);
`endif
        chk("op_d_A", alu_matrizA, exp_a);
        chk("op_d_B", alu_matrizB, exp_b);
        nop();
        issue(4'hE, 1'b0, 5'd0, 8'h00);
        wait_idle(c);
        chk1("op_e_err", err, 1'b1);
        nop();

        // Reset on EXEC cycle 5
        mode = M_NEVER;
        issue(4'h6, 1'b0, 5'd0, 8'h33);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("midrst_busy", busy, 1'b0);
        chk("midrst_opcode", 200'(alu_opcode), 200'(0));
        chk("midrst_A", alu_matrizA, '0);
        chk("midrst_B", alu_matrizB, '0);
        chk1("midrst_ready", instr_ready, 1'b0);
        reset = 1'b0;
        exp_a = '0;
        exp_b = '0;
        mode  = M_ADD;
        store(5'd6, 8'h00);
        store(5'd0, 8'h00);

        // Backpressure: STORE held during EXEC, accepted once afterwards
        load(1'b0, 5'd2, 8'd7);
        load(1'b1, 5'd2, 8'd9);
        issue(4'h7, 1'b0, 5'd0, 8'h00);
        exp_q.push_back(8'd16);
        instr       = {14'd0, 8'h00, 5'd2, 1'b0, 4'h2};
        instr_valid = 1'b1;
        rdy_bad     = 0;
        busy_seen   = 0;
        @(negedge clk);
        while (busy && busy_seen < 500) begin
            if (instr_ready) rdy_bad++;
            busy_seen++;
            @(negedge clk);
        end
        chkn("bp_ready_while_busy", rdy_bad, 0);
        chkn("bp_busy_cycles", busy_seen, 3);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wait_idle(c);
        repeat (4) @(negedge clk);

        chkn("store_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
